// File: rtl/el2_dec_trigger_ctl.sv
// el2_dec_trigger_ctl: decode-stage trigger qualification, chaining and
// hit handshake toward the TLU, with per-trigger re-arm delay.
//
// Ports:
//   clk, rst         core clock, synchronous active-high reset
//   trig_match_raw   per-trigger raw match from the trigger datapath
//   trig_chain       bit0 chains triggers 0-1, bit2 chains triggers 2-3
//   trig_action      per-trigger action (0 breakpoint, 1 debug halt)
//   trig_cfg_wr      per-trigger tdata1/tdata2 write strobe
//   dec_valid_d      decode-stage instruction valid
//   dbg_mode         core is in debug mode
//   hit_ack          TLU accepts the pending hit
//   hit_req          hit pending to TLU
//   hit_vec          captured trigger hits
//   hit_halt         captured hit requests a debug halt
//   stall_d          hold decode while a hit is pending or halted
//   trig_armed       per-trigger armed status
module el2_dec_trigger_ctl #(
   parameter int unsigned ARM_DELAY = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] trig_match_raw,
   input  logic [3:0] trig_chain,
   input  logic [3:0] trig_action,
   input  logic [3:0] trig_cfg_wr,
   input  logic       dec_valid_d,
   input  logic       dbg_mode,
   input  logic       hit_ack,
   output logic       hit_req,
   output logic [3:0] hit_vec,
   output logic       hit_halt,
   output logic       stall_d,
   output logic [3:0] trig_armed
);

   localparam logic [2:0] ARM_LD = 3'(ARM_DELAY);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_PEND   = 2'd1,
      S_HALTED = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [3:0][2:0] cnt_q, cnt_d;
   logic [3:0]      hit_vec_q, hit_vec_d;
   logic            hit_halt_q, hit_halt_d;
   logic            dbg_mode_q;

   logic [3:0]      qual;
   logic [3:0]      eff;
   logic            dbg_fall;
   logic            pair01;
   logic            pair23;

   // Odd chain bits have no partner trigger.
   logic            unused_chain;
   assign unused_chain = trig_chain[1] ^ trig_chain[3];

   // Arm counters: a config write (re)loads the delay, then counts
   // down; the trigger is armed only once the count reaches zero.
   always_comb begin
      cnt_d      = cnt_q;
      trig_armed = 4'h0;
      for (int i = 0; i < 4; i++) begin
         trig_armed[i] = (cnt_q[i] == 3'd0);
         if (trig_cfg_wr[i]) begin
            cnt_d[i] = ARM_LD;
         end else if (cnt_q[i] != 3'd0) begin
            cnt_d[i] = cnt_q[i] - 3'd1;
         end
      end
   end

   // A same-cycle config write always suppresses its own trigger.
   assign qual = trig_match_raw
               & trig_armed
               & ~trig_cfg_wr
               & {4{dec_valid_d & ~dbg_mode}};

   assign pair01 = qual[0] & qual[1];
   assign pair23 = qual[2] & qual[3];

   always_comb begin
      eff = qual;
      if (trig_chain[0]) begin
         eff[0] = pair01;
         eff[1] = pair01;
      end
      if (trig_chain[2]) begin
         eff[2] = pair23;
         eff[3] = pair23;
      end
   end

   assign dbg_fall = dbg_mode_q & ~dbg_mode;

   // Matches outside IDLE are dropped; the capture registers
   // only change on an IDLE -> PEND transition.
   always_comb begin
      state_d    = state_q;
      hit_vec_d  = hit_vec_q;
      hit_halt_d = hit_halt_q;
      unique case (state_q)
         S_IDLE: begin
            if (|eff) begin
               state_d    = S_PEND;
               hit_vec_d  = eff;
               hit_halt_d = |(eff & trig_action);
            end
         end
         S_PEND: begin
            if (hit_ack) begin
               state_d = hit_halt_q ? S_HALTED : S_IDLE;
            end
         end
         S_HALTED: begin
            if (dbg_fall) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         hit_vec_q  <= 4'h0;
         hit_halt_q <= 1'b0;
         dbg_mode_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         hit_vec_q  <= hit_vec_d;
         hit_halt_q <= hit_halt_d;
         dbg_mode_q <= dbg_mode;
      end
   end

   // Handshake outputs come straight from the state register.
   assign hit_req  = (state_q == S_PEND);
   assign stall_d  = (state_q != S_IDLE);
   assign hit_vec  = hit_vec_q;
   assign hit_halt = hit_halt_q;

endmodule

// File: tb/tb_el2_dec_trigger_ctl.sv
// tb_el2_dec_trigger_ctl: directed stimulus with a hit scoreboard;
// a monitor pops the expected capture on each new hit_req.
module tb_el2_dec_trigger_ctl;

   logic       clk;
   logic       rst;
   logic [3:0] raw;
   logic [3:0] chain;
   logic [3:0] action;
   logic [3:0] cfg_wr;
   logic       valid;
   logic       dbg;
   logic       ack;
   logic       hit_req;
   logic [3:0] hit_vec;
   logic       hit_halt;
   logic       stall_d;
   logic [3:0] armed;

   typedef struct packed {
      logic [3:0] vec;
      logic       halt;
   } exp_t;

   exp_t sb[$];
   int   errs;
   int   checks;
   logic prev_req;

   el2_dec_trigger_ctl #(.ARM_DELAY(2)) dut (
      .clk            (clk),
      .rst            (rst),
      .trig_match_raw (raw),
      .trig_chain     (chain),
      .trig_action    (action),
      .trig_cfg_wr    (cfg_wr),
      .dec_valid_d    (valid),
      .dbg_mode       (dbg),
      .hit_ack        (ack),
      .hit_req        (hit_req),
      .hit_vec        (hit_vec),
      .hit_halt       (hit_halt),
      .stall_d        (stall_d),
      .trig_armed     (armed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm,
                      input logic [7:0] act,
                      input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every new hit presented to the TLU must match the
   // oldest expected capture.
   initial prev_req = 1'b0;
   always @(negedge clk) begin
      if (hit_req && !prev_req) begin
         if (sb.size() == 0) begin
            checks++;
            errs++;
            $display("FAIL sb_unexpected: vec=%b halt=%b",
                     hit_vec, hit_halt);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_capture", {3'd0, hit_vec, hit_halt},
                {3'd0, e.vec, e.halt});
         end
      end
      prev_req = hit_req;
   end

   initial begin
      errs   = 0;
      checks = 0;
      rst    = 1'b1;
      raw    = 4'h0;
      chain  = 4'h0;
      action = 4'h0;
      cfg_wr = 4'h0;
      valid  = 1'b0;
      dbg    = 1'b0;
      ack    = 1'b0;
      step();
      step();
      chk("rst_req", {7'd0, hit_req}, 8'h00);
      chk("rst_stall", {7'd0, stall_d}, 8'h00);
      chk("rst_vec", {4'd0, hit_vec}, 8'h00);
      chk("rst_halt", {7'd0, hit_halt}, 8'h00);
      chk("rst_armed", {4'd0, armed}, 8'h0F);
      rst   = 1'b0;
      valid = 1'b1;
      step();

      // single breakpoint hit, one-cycle latency
      raw = 4'b0100;
      sb.push_back('{vec: 4'b0100, halt: 1'b0});
      step();
      chk("t1_req", {7'd0, hit_req}, 8'h01);
      chk("t1_stall", {7'd0, stall_d}, 8'h01);
      raw = 4'h0;
      ack = 1'b1;
      step();
      ack = 1'b0;
      chk("t1_ack_req", {7'd0, hit_req}, 8'h00);
      chk("t1_ack_stall", {7'd0, stall_d}, 8'h00);

      // chained pair 0-1
      chain = 4'b0001;
      raw   = 4'b0001;
      step();
      chk("t2_half", {7'd0, hit_req}, 8'h00);
      raw = 4'b0011;
      sb.push_back('{vec: 4'b0011, halt: 1'b0});
      step();
      chk("t2_req", {7'd0, hit_req}, 8'h01);
      chk("t2_vec", {4'd0, hit_vec}, 8'h03);
      raw = 4'h0;
      ack = 1'b1;
      step();
      ack = 1'b0;

      // chained pair 2-3
      chain = 4'b0100;
      raw   = 4'b1000;
      step();
      chk("t2b_half", {7'd0, hit_req}, 8'h00);
      raw = 4'b1100;
      sb.push_back('{vec: 4'b1100, halt: 1'b0});
      step();
      chk("t2b_vec", {4'd0, hit_vec}, 8'h0C);
      raw   = 4'h0;
      chain = 4'h0;
      ack   = 1'b1;
      step();
      ack = 1'b0;

      // arm delay after config write to trigger 1
      raw    = 4'b0010;
      cfg_wr = 4'b0010;
      step();
      cfg_wr = 4'h0;
      chk("t3_n1_armed", {4'd0, armed}, 8'h0D);
      chk("t3_n1_req", {7'd0, hit_req}, 8'h00);
      step();
      chk("t3_n2_armed", {4'd0, armed}, 8'h0D);
      chk("t3_n2_req", {7'd0, hit_req}, 8'h00);
      sb.push_back('{vec: 4'b0010, halt: 1'b0});
      step();
      chk("t3_n3_armed", {4'd0, armed}, 8'h0F);
      chk("t3_n3_req", {7'd0, hit_req}, 8'h00);
      step();
      chk("t3_n4_req", {7'd0, hit_req}, 8'h01);
      raw = 4'h0;
      ack = 1'b1;
      step();
      ack = 1'b0;

      // reload while counting
      cfg_wr = 4'b0001;
      step();
      step();
      cfg_wr = 4'h0;
      step();
      chk("t4_reload", {4'd0, armed}, 8'h0E);
      step();
      chk("t4_rearmed", {4'd0, armed}, 8'h0F);

      // debug-halt hit, HALTED behaviour
      action = 4'b1000;
      raw    = 4'b1000;
      sb.push_back('{vec: 4'b1000, halt: 1'b1});
      step();
      chk("t5_halt", {7'd0, hit_halt}, 8'h01);
      raw = 4'h0;
      ack = 1'b1;
      step();
      chk("t5_h_req", {7'd0, hit_req}, 8'h00);
      chk("t5_h_stall", {7'd0, stall_d}, 8'h01);
      raw = 4'b1000;
      step();
      chk("t5_drop", {7'd0, hit_req}, 8'h00);
      chk("t5_ackign", {7'd0, stall_d}, 8'h01);
      raw = 4'h0;
      ack = 1'b0;
      dbg = 1'b1;
      step();
      chk("t5_dbg_stall", {7'd0, stall_d}, 8'h01);
      dbg = 1'b0;
      step();
      chk("t5_exit", {7'd0, stall_d}, 8'h00);
      action = 4'h0;

      // config writes during PEND leave the hit alone
      raw = 4'b0010;
      sb.push_back('{vec: 4'b0010, halt: 1'b0});
      step();
      for (int i = 0; i < 3; i++) begin
         cfg_wr = 4'b0001;
         step();
         chk("t6_req", {7'd0, hit_req}, 8'h01);
         chk("t6_vec", {4'd0, hit_vec}, 8'h02);
      end
      cfg_wr = 4'h0;
      raw    = 4'h0;
      ack    = 1'b1;
      step();
      ack = 1'b0;
      chk("t6_done", {7'd0, hit_req}, 8'h00);

      // reset during PEND
      raw = 4'b0100;
      sb.push_back('{vec: 4'b0100, halt: 1'b0});
      step();
      raw    = 4'h0;
      cfg_wr = 4'b0001;
      step();
      chk("t7_pend", {7'd0, hit_req}, 8'h01);
      cfg_wr = 4'h0;
      rst    = 1'b1;
      step();
      rst = 1'b0;
      chk("t7_req", {7'd0, hit_req}, 8'h00);
      chk("t7_vec", {4'd0, hit_vec}, 8'h00);
      chk("t7_armed", {4'd0, armed}, 8'h0F);
      chk("t7_stall", {7'd0, stall_d}, 8'h00);

      // qualification by valid and debug mode, ack in IDLE
      raw   = 4'hF;
      valid = 1'b0;
      step();
      chk("t8_novalid", {7'd0, hit_req}, 8'h00);
      valid = 1'b1;
      dbg   = 1'b1;
      step();
      chk("t8_dbg", {7'd0, hit_req}, 8'h00);
      dbg = 1'b0;
      raw = 4'h0;
      ack = 1'b1;
      step();
      ack = 1'b0;
      chk("t8_ackidle", {7'd0, stall_d}, 8'h00);

      // mixed actions on two triggers
      raw    = 4'b0101;
      action = 4'b0100;
      sb.push_back('{vec: 4'b0101, halt: 1'b1});
      step();
      chk("t9_vec", {4'd0, hit_vec}, 8'h05);
      raw = 4'h0;
      ack = 1'b1;
      step();
      ack = 1'b0;
      chk("t9_halted", {7'd0, stall_d}, 8'h01);
      dbg = 1'b1;
      step();
      dbg = 1'b0;
      step();
      chk("t9_exit", {7'd0, stall_d}, 8'h00);
      chk("t9_hold", {4'd0, hit_vec}, 8'h05);

      step();
      step();
      chk("sb_empty", 8'(sb.size()), 8'h00);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
